// File: rtl/phase_sequencer.sv
// Phase sequencer: NUM_PHASES non-overlapping strobes per frame. It also sequences
// core reset, handles halt/resume/restart, and drives a retriggerable flush pulse.
module phase_sequencer #(
    parameter int unsigned NUM_PHASES       = 2,
    parameter int unsigned PHASE_TICKS      = 1,
    parameter int unsigned GAP_TICKS        = 1,
    parameter int unsigned INIT_CYCLES      = 2,
    parameter int unsigned FLUSH_TICKS      = 1,
    parameter int unsigned HALT_AT_BOUNDARY = 1,
    parameter int unsigned CNT_W            = 16
) (
    input  logic                  internal_clock,
    input  logic                  reset,
    input  logic                  controller_enable,
    input  logic                  halted,
    input  logic                  resume,
    input  logic                  restart,
    input  logic                  flush_detected,
    output logic [NUM_PHASES-1:0] phase,
    output logic                  cpu_reset,
    output logic                  enable,
    output logic                  flush,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      frame_count
);

    localparam int unsigned SLOT_TICKS  = PHASE_TICKS + GAP_TICKS;
    localparam int unsigned FRAME_TICKS = NUM_PHASES * SLOT_TICKS;
    localparam int unsigned TICK_W      = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int unsigned INIT_W      = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned FLUSH_W     = $clog2(FLUSH_TICKS + 1);

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
    localparam logic [INIT_W-1:0]  INIT_LAST  = INIT_W'(INIT_CYCLES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_TICKS);

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    state_t                  r_state;
    logic [TICK_W-1:0]       r_tick;
    logic [INIT_W-1:0]       r_init_cnt;
    logic                    r_halt_req;
    logic                    r_restart_req;
    logic [FLUSH_W-1:0]      r_flush_cnt;
    logic                    r_fd_q;
    logic [CNT_W-1:0]        r_frame_count;
    logic [NUM_PHASES-1:0]   r_phase;
    logic                    r_cpu_reset;
    logic                    r_enable;
    logic                    r_flush;

    state_t                  w_state_nxt;
    logic [TICK_W-1:0]       w_tick_nxt;
    logic [INIT_W-1:0]       w_init_nxt;
    logic                    w_halt_req_nxt;
    logic                    w_restart_req_nxt;
    logic [FLUSH_W-1:0]      w_flush_cnt_nxt;
    logic [CNT_W-1:0]        w_frame_nxt;
    logic                    w_fd_rise;
    logic                    w_restart_pend;
    logic                    w_restart_svc;
    logic                    w_tick_last;
    logic                    w_halt_any;

    // Strobe k is high in the first PHASE_TICKS cycles of slot k, only while running and gated.
    function automatic logic [NUM_PHASES-1:0] decode_phase(input state_t st, input logic gate,
                                                           input logic [TICK_W-1:0] tick);
        logic [NUM_PHASES-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < NUM_PHASES; k++) begin
            if ((32'(tick) >= k * SLOT_TICKS) && (32'(tick) < k * SLOT_TICKS + PHASE_TICKS)) begin
                v[k] = 1'b1;
            end
        end
        if ((st != ST_RUN) || !gate) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        w_fd_rise         = flush_detected & ~r_fd_q;
        w_restart_pend    = r_restart_req | restart;
        w_restart_svc     = w_restart_pend & controller_enable;
        w_tick_last       = (r_tick == TICK_LAST);
        w_halt_any        = r_halt_req | halted;

        w_state_nxt       = r_state;
        w_tick_nxt        = r_tick;
        w_init_nxt        = r_init_cnt;
        w_frame_nxt       = r_frame_count;
        w_restart_req_nxt = w_restart_pend;
        // A simultaneous halt wins over resume, so the request survives.
        w_halt_req_nxt    = halted ? 1'b1 : (resume ? 1'b0 : r_halt_req);
        if (w_fd_rise) begin
            w_flush_cnt_nxt = FLUSH_LOAD;
        end else if (r_flush_cnt != '0) begin
            w_flush_cnt_nxt = r_flush_cnt - FLUSH_W'(1);
        end else begin
            w_flush_cnt_nxt = r_flush_cnt;
        end

        if (w_restart_svc) begin
            w_state_nxt       = ST_INIT;
            w_tick_nxt        = '0;
            w_init_nxt        = '0;
            w_frame_nxt       = '0;
            w_halt_req_nxt    = 1'b0;
            w_restart_req_nxt = 1'b0;
            w_flush_cnt_nxt   = '0;
        end else if (r_state == ST_BAD) begin
            w_state_nxt = ST_INIT;
            w_tick_nxt  = '0;
            w_init_nxt  = '0;
        end else if (controller_enable) begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == INIT_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_tick_nxt  = '0;
                    end else begin
                        w_init_nxt = r_init_cnt + INIT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (w_tick_last) begin
                        w_frame_nxt = r_frame_count + CNT_W'(1);
                    end
                    w_tick_nxt = w_tick_last ? '0 : r_tick + TICK_W'(1);
                    if (w_halt_any && (w_tick_last || (HALT_AT_BOUNDARY == 0))) begin
                        w_state_nxt = ST_HALT;
                        w_tick_nxt  = '0;
                    end
                end
                ST_HALT: begin
                    if (resume && !halted) begin
                        w_state_nxt = ST_RUN;
                        w_tick_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_INIT;
                end
            endcase
        end
    end

    // Outputs are registered from next-state values; the gate is the sampled controller_enable.
    always_ff @(posedge internal_clock) begin
        if (reset) begin
            r_state       <= ST_INIT;
            r_tick        <= '0;
            r_init_cnt    <= '0;
            r_halt_req    <= 1'b0;
            r_restart_req <= 1'b0;
            r_flush_cnt   <= '0;
            r_fd_q        <= 1'b0;
            r_frame_count <= '0;
            r_phase       <= '0;
            r_cpu_reset   <= 1'b1;
            r_enable      <= 1'b0;
            r_flush       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tick        <= w_tick_nxt;
            r_init_cnt    <= w_init_nxt;
            r_halt_req    <= w_halt_req_nxt;
            r_restart_req <= w_restart_req_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
            r_fd_q        <= flush_detected;
            r_frame_count <= w_frame_nxt;
            r_phase       <= decode_phase(w_state_nxt, controller_enable, w_tick_nxt);
            r_cpu_reset   <= (w_state_nxt != ST_RUN) && (w_state_nxt != ST_HALT);
            r_enable      <= 1'b1;
            r_flush       <= (w_flush_cnt_nxt != '0);
        end
    end

    assign phase       = r_phase;
    assign cpu_reset   = r_cpu_reset;
    assign enable      = r_enable;
    assign flush       = r_flush;
    assign state       = r_state;
    assign frame_count = r_frame_count;

endmodule
